// File: rtl/apb_master_bridge.sv
// Host valid/ready to APB requester driving two slaves through SETUP/ACCESS phases.
// Optional ACCESS-phase timeout abort is enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int WIDTH          = 32,
    parameter int SEL_BIT        = 7,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic             PSEL1,
    output logic             PSEL2,
    output logic             PENABLE,
    output logic             PWRITE,
    output logic [WIDTH-1:0] paddr,
    output logic [WIDTH-1:0] pwdata,
    input  logic             PREADY1,
    input  logic             PREADY2,
    input  logic [WIDTH-1:0] prdata1,
    input  logic [WIDTH-1:0] prdata2
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_DERR
    } state_t;

    localparam logic [WIDTH-1:0] ADDR_MASK = (WIDTH'(1) << SEL_BIT) - WIDTH'(1);

    state_t           state_q, state_d;
    logic             psel1_q, psel1_d;
    logic             psel2_q, psel2_d;
    logic             penable_q, penable_d;
    logic             pwrite_q, pwrite_d;
    logic [WIDTH-1:0] paddr_q, paddr_d;
    logic [WIDTH-1:0] pwdata_q, pwdata_d;
    logic             resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic             resp_err_q, resp_err_d;
    logic             decode_err;
    logic             slave_ready;
    logic [WIDTH-1:0] slave_rdata;
    logic             xfer_done;

`ifdef APB_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TIMER_W-1:0] timer_q, timer_d;
`else
    // The timeout limit has no effect in this build.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    assign req_ready   = (state_q == ST_IDLE) && !PRESET;
    assign decode_err  = |(req_addr >> (SEL_BIT + 1));
    // Only the selected slave's handshake is ever looked at.
    assign slave_ready = psel2_q ? PREADY2 : PREADY1;
    assign slave_rdata = psel2_q ? prdata2 : prdata1;

    always_comb begin
        state_d      = state_q;
        psel1_d      = psel1_q;
        psel2_d      = psel2_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        xfer_done    = 1'b0;
`ifdef APB_TIMEOUT_EN
        timer_d      = timer_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    if (decode_err) begin
                        state_d = ST_DERR;
                    end else begin
                        state_d  = ST_SETUP;
                        psel1_d  = !req_addr[SEL_BIT];
                        psel2_d  = req_addr[SEL_BIT];
                        pwrite_d = req_write;
                        paddr_d  = req_addr & ADDR_MASK;
                        pwdata_d = req_wdata;
                    end
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
                timer_d   = '0;
`endif
            end
            ST_ACCESS: begin
                if (slave_ready) begin
                    xfer_done    = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = pwrite_q ? '0 : slave_rdata;
                end
`ifdef APB_TIMEOUT_EN
                else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    xfer_done    = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
`endif
            end
            ST_DERR: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Completion or abort returns every bus output to zero for IDLE.
        if (xfer_done) begin
            state_d   = ST_IDLE;
            psel1_d   = 1'b0;
            psel2_d   = 1'b0;
            penable_d = 1'b0;
            pwrite_d  = 1'b0;
            paddr_d   = '0;
            pwdata_d  = '0;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q      <= ST_IDLE;
            psel1_q      <= 1'b0;
            psel2_q      <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            timer_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            psel1_q      <= psel1_d;
            psel2_q      <= psel2_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
`ifdef APB_TIMEOUT_EN
            timer_q      <= timer_d;
`endif
        end
    end

    assign PSEL1      = psel1_q;
    assign PSEL2      = psel2_q;
    assign PENABLE    = penable_q;
    assign PWRITE     = pwrite_q;
    assign paddr      = paddr_q;
    assign pwdata     = pwdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized self-checking bench for apb_master_bridge with two behavioural APB slaves.
// Timeout scenarios are included when APB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_apb_master_bridge;

    localparam int TIMEOUT_CYCLES = 16;

    logic        PCLK;
    logic        PRESET;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        PSEL1, PSEL2, PENABLE, PWRITE;
    logic [31:0] paddr, pwdata;
    logic        PREADY1, PREADY2;
    logic [31:0] prdata1, prdata2;

    int errors = 0;
    int checks = 0;

    // Slave environment state, index 0 = slave1, 1 = slave2
    logic        rdy [2];
    int          wc [2];
    int          stale [2];
    int          wait_cyc [2];
    bit          never_rdy [2];
    bit          stale_mode;
    bit          mem_clear;
    logic [31:0] mem [2][128];
    logic [31:0] prd [2];
    logic        psel_v [2];

    // Reference view of slave contents, updated when a request is issued
    logic [31:0] ref_mem [2][128];

    apb_master_bridge #(
        .WIDTH(32),
        .SEL_BIT(7),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .PCLK(PCLK),
        .PRESET(PRESET),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .PSEL1(PSEL1),
        .PSEL2(PSEL2),
        .PENABLE(PENABLE),
        .PWRITE(PWRITE),
        .paddr(paddr),
        .pwdata(pwdata),
        .PREADY1(PREADY1),
        .PREADY2(PREADY2),
        .prdata1(prdata1),
        .prdata2(prdata2)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    assign psel_v[0] = PSEL1;
    assign psel_v[1] = PSEL2;
    assign PREADY1   = rdy[0] | (stale[0] != 0);
    assign PREADY2   = rdy[1] | (stale[1] != 0);
    assign prdata1   = prd[0];
    assign prdata2   = prd[1];

    // Slaves raise PREADY one cycle after PSEL&PENABLE plus optional wait states;
    // stale mode keeps PREADY high for two extra cycles after completion.
    always @(posedge PCLK) begin
        if (mem_clear) begin
            for (int k = 0; k < 128; k++) begin
                mem[0][k] <= 32'h0;
                mem[1][k] <= 32'h0;
            end
        end
        for (int s = 0; s < 2; s++) begin
            if (PRESET) begin
                rdy[s]   <= 1'b0;
                wc[s]    <= 0;
                stale[s] <= 0;
            end else if (rdy[s]) begin
                rdy[s] <= 1'b0;
                wc[s]  <= 0;
                if (stale_mode) stale[s] <= 2;
            end else begin
                if (stale[s] > 0) stale[s] <= stale[s] - 1;
                if (psel_v[s] && PENABLE && !never_rdy[s]) begin
                    if (wc[s] >= wait_cyc[s]) begin
                        rdy[s] <= 1'b1;
                        wc[s]  <= 0;
                        if (PWRITE) mem[s][paddr[6:0]] <= pwdata;
                        else        prd[s] <= mem[s][paddr[6:0]];
                    end else begin
                        wc[s] <= wc[s] + 1;
                    end
                end else begin
                    wc[s] <= 0;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Issue one request from a negedge and follow it to its response, checking every bus cycle.
    task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                                 input bit hold, input int waitc, output time t_acc);
        bit          derr;
        int          s;
        int          idx;
        int          exp_lat;
        logic [31:0] exp_rd;
        bit          exp_err;
        logic [31:0] exp_paddr;
        int          lat;
        int          n;
        bit          got_resp;
        derr      = (addr >> 8) != 0;
        s         = int'(addr[7]);
        idx       = int'(addr[6:0]);
        exp_paddr = addr & 32'h7F;
        exp_err   = derr;
        exp_rd    = 32'h0;
        exp_lat   = derr ? 2 : 4 + waitc;
        if (!derr) begin
            wait_cyc[s] = waitc;
            if (!wr) exp_rd = ref_mem[s][idx];
`ifdef APB_TIMEOUT_EN
            if (never_rdy[s] || (waitc + 2 > TIMEOUT_CYCLES)) begin
                exp_err = 1'b1;
                exp_rd  = 32'h0;
                exp_lat = 2 + TIMEOUT_CYCLES;
            end
`endif
            if (wr && !exp_err) ref_mem[s][idx] = wd;
        end

        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 64) begin
            @(negedge PCLK);
            n++;
        end
        t_acc = $time;
        if (!req_ready) begin
            checkOutput("accept_wait", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end

        lat      = 0;
        got_resp = 1'b0;
        while (!got_resp && lat < 64) begin
            @(negedge PCLK);
            lat++;
            if (!hold) req_valid = 1'b0;
            if (resp_valid) begin
                got_resp = 1'b1;
                checkOutput("latency", 32'(lat), 32'(exp_lat));
                checkOutput("resp_rdata", resp_rdata, exp_rd);
                checkOutput("resp_err", {31'h0, resp_err}, {31'h0, exp_err});
                checkOutput("idle_bus", {29'h0, PSEL1, PSEL2, PENABLE}, 32'h0);
                checkOutput("idle_paddr", paddr, 32'h0);
            end else if (derr) begin
                checkOutput("derr_nosel", {29'h0, PSEL1, PSEL2, PENABLE}, 32'h0);
            end else if (lat == 1) begin
                checkOutput("setup_psel", {30'h0, PSEL1, PSEL2}, (s == 1) ? 32'h1 : 32'h2);
                checkOutput("setup_penable", {31'h0, PENABLE}, 32'h0);
                checkOutput("setup_paddr", paddr, exp_paddr);
                checkOutput("setup_pwrite", {31'h0, PWRITE}, {31'h0, wr});
                if (wr) checkOutput("setup_pwdata", pwdata, wd);
            end else begin
                checkOutput("access_psel", {30'h0, PSEL1, PSEL2}, (s == 1) ? 32'h1 : 32'h2);
                checkOutput("access_penable", {31'h0, PENABLE}, 32'h1);
                checkOutput("access_paddr", paddr, exp_paddr);
            end
        end
        if (!got_resp) checkOutput("resp_wait", 32'd0, 32'd1);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge PCLK);
            checkOutput("idle_quiet", {28'h0, PSEL1, PSEL2, PENABLE, resp_valid}, 32'h0);
            checkOutput("idle_ready", {31'h0, req_ready}, 32'h1);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput(tag, {27'h0, PSEL1, PSEL2, PENABLE, PWRITE, resp_valid}, 32'h0);
        checkOutput({tag, "_paddr"}, paddr, 32'h0);
        checkOutput({tag, "_pwdata"}, pwdata, 32'h0);
        checkOutput({tag, "_rdata"}, resp_rdata, 32'h0);
        checkOutput({tag, "_err"}, {31'h0, resp_err}, 32'h0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        time         t0, t1, t2, t3;
        logic [31:0] a;
        bit          w;
        bit          h;
        int          wt;

        PRESET     = 1'b1;
        mem_clear  = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        stale_mode = 1'b0;
        for (int s = 0; s < 2; s++) begin
            wait_cyc[s]  = 0;
            never_rdy[s] = 1'b0;
            for (int k = 0; k < 128; k++) ref_mem[s][k] = 32'h0;
        end

        repeat (3) @(negedge PCLK);
        checkAllZero("reset");
        checkOutput("reset_ready", {31'h0, req_ready}, 32'h0);
        mem_clear = 1'b0;
        PRESET    = 1'b0;
        #1;
        checkOutput("release_ready", {31'h0, req_ready}, 32'h1);
        @(negedge PCLK);

        $display("[TB] directed: slave1/slave2 routing and decode error");
        applyStimulus(1'b1, 32'h05, 32'hDEADBEEF, 1'b0, 0, t0);
        applyStimulus(1'b0, 32'h05, 32'h0, 1'b0, 0, t0);
        applyStimulus(1'b1, 32'h85, 32'h12345678, 1'b0, 0, t0);
        applyStimulus(1'b0, 32'h85, 32'h0, 1'b0, 0, t0);
        applyStimulus(1'b0, 32'h05, 32'h0, 1'b0, 0, t0);
        applyStimulus(1'b0, 32'h100, 32'h0, 1'b0, 0, t0);
        idleCycles(2);

        $display("[TB] back-to-back with held valid and stale PREADY");
        stale_mode = 1'b1;
        applyStimulus(1'b1, 32'h10, 32'hA5A50001, 1'b1, 0, t1);
        applyStimulus(1'b1, 32'h11, 32'hA5A50002, 1'b1, 0, t2);
        applyStimulus(1'b1, 32'h92, 32'hA5A50003, 1'b1, 0, t3);
        checkOutput("b2b_gap1", 32'((t2 - t1) / 10), 32'd4);
        checkOutput("b2b_gap2", 32'((t3 - t2) / 10), 32'd4);
        applyStimulus(1'b0, 32'h10, 32'h0, 1'b1, 0, t1);
        applyStimulus(1'b0, 32'h11, 32'h0, 1'b1, 0, t2);
        applyStimulus(1'b0, 32'h92, 32'h0, 1'b1, 0, t3);
        req_valid = 1'b0;
        idleCycles(3);
        stale_mode = 1'b0;

        $display("[TB] reset during ACCESS");
        wait_cyc[0] = 6;
        req_write   = 1'b0;
        req_addr    = 32'h05;
        req_valid   = 1'b1;
        checkOutput("rst_pre_ready", {31'h0, req_ready}, 32'h1);
        @(negedge PCLK);
        req_valid = 1'b0;
        @(negedge PCLK);
        checkOutput("rst_in_access", {30'h0, PSEL1, PENABLE}, 32'h3);
        PRESET = 1'b1;
        @(negedge PCLK);
        checkAllZero("rst_abort");
        checkOutput("rst_ready_low", {31'h0, req_ready}, 32'h0);
        PRESET = 1'b0;
        #1;
        checkOutput("rst_ready_high", {31'h0, req_ready}, 32'h1);
        idleCycles(10);

        $display("[TB] randomized transfers");
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            h = 1'($urandom_range(0, 1));
            wt = $urandom_range(0, 3);
            stale_mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = $urandom() | 32'h100;
            else a = (32'($urandom_range(0, 1)) << 7) | 32'($urandom_range(0, 7));
            applyStimulus(w, a, $urandom(), h, wt, t0);
        end
        req_valid  = 1'b0;
        stale_mode = 1'b0;
        idleCycles(3);

`ifdef APB_TIMEOUT_EN
        $display("[TB] ACCESS timeout");
        never_rdy[0] = 1'b1;
        applyStimulus(1'b0, 32'h05, 32'h0, 1'b0, 0, t0);
        idleCycles(3);
        never_rdy[0] = 1'b0;
        applyStimulus(1'b0, 32'h05, 32'h0, 1'b0, TIMEOUT_CYCLES - 2, t0);
        applyStimulus(1'b0, 32'h06, 32'h0, 1'b0, TIMEOUT_CYCLES - 1, t0);
        idleCycles(3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
